// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and helpers for the multi-channel tick
// generator.
//   CNT_W_DEF  default counter/period width (1 s at 25 MHz fits)
//   CH_IDX_W   width of the write/readback channel index
//   DIV_HALT   period value that halts a channel
//   DIV_*      named periods for a 25 MHz system clock
package tick_gen_pkg;

   localparam int CNT_W_DEF = 25;
   localparam int CH_IDX_W  = 4;
   localparam int DIV_HALT  = 0;

   localparam int DIV_1KHZ  = 25000;
   localparam int DIV_10HZ  = 2500000;
   localparam int DIV_1HZ   = 25000000;

   // True when a channel index addresses an implemented channel.
   function automatic logic ch_in_range(input logic [CH_IDX_W-1:0] idx,
                                        input int                  num_ch);
      ch_in_range = (32'(idx) < num_ch);
   endfunction

endpackage

// File: rtl/tick_chan.sv
// tick_chan: one tick-generator channel.
//   clk, rst   system clock, synchronous active-high reset
//   load       take load_div as the new period and restart the phase
//   load_div   new period in clk cycles (0 halts the channel)
//   restart    restart the phase without touching period or square wave
//   div        current period register
//   tick       registered one-cycle pulse once per period
//   sq         square wave toggling on each tick (TICK_GEN_SQUARE_EN),
//              otherwise tied to 0
import tick_gen_pkg::*;

module tick_chan #(
   parameter int               CNT_W   = CNT_W_DEF,
   parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_1KHZ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_div,
   input  logic             restart,
   output logic [CNT_W-1:0] div,
   output logic             tick,
   output logic             sq
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             tick_nxt;

   // Next-state: load beats restart beats counting. A load on the wrap
   // cycle drops that tick, and cnt never passes div-1.
   always_comb begin
      div_nxt  = div;
      cnt_nxt  = cnt;
      tick_nxt = 1'b0;
      if (load) begin
         div_nxt = load_div;
         cnt_nxt = '0;
      end else if (restart) begin
         cnt_nxt = '0;
      end else if (div == CNT_W'(DIV_HALT)) begin
         cnt_nxt = '0;
      end else if (cnt == (div - ONE)) begin
         cnt_nxt  = '0;
         tick_nxt = 1'b1;
      end else begin
         cnt_nxt = cnt + ONE;
      end
   end

   // Period, counter and tick registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         div  <= DIV_RST;
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         div  <= div_nxt;
         cnt  <= cnt_nxt;
         tick <= tick_nxt;
      end
   end

`ifdef TICK_GEN_SQUARE_EN
   // Square wave: flips in every cycle where tick is high, giving 2*div
   // period at 50% duty; a load clears it, a restart leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         sq <= 1'b0;
      end else if (load) begin
         sq <= 1'b0;
      end else if (restart) begin
         sq <= sq;
      end else begin
         sq <= sq ^ tick;
      end
   end
`else
   assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: parametrised multi-channel tick generator on a single clock.
// Optional feature macro: TICK_GEN_SQUARE_EN enables the sq outputs.
//   clk, rst   system clock, synchronous active-high reset
//   wr_en      period write strobe
//   wr_ch      channel index for the write (out of range is ignored)
//   wr_div     new period in clk cycles
//   rd_ch      channel index for readback
//   rd_div     registered period of rd_ch (0 for out-of-range index)
//   sync       restart the phase of every channel
//   tick       one-cycle pulse per channel period
//   sq         square wave per channel, period 2*div
import tick_gen_pkg::*;

module tick_gen #(
   parameter int                      NUM_CH   = 8,
   parameter int                      CNT_W    = CNT_W_DEF,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {NUM_CH{CNT_W'(DIV_1KHZ)}}
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [CH_IDX_W-1:0] wr_ch,
   input  logic [CNT_W-1:0]    wr_div,
   input  logic [CH_IDX_W-1:0] rd_ch,
   output logic [CNT_W-1:0]    rd_div,
   input  logic                sync,
   output logic [NUM_CH-1:0]   tick,
   output logic [NUM_CH-1:0]   sq
);

   logic [CNT_W-1:0] div_all [NUM_CH];
   logic [CNT_W-1:0] rd_sel;
   logic             wr_ok;

   assign wr_ok = wr_en && ch_in_range(wr_ch, NUM_CH);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      tick_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .load     (wr_ok && (wr_ch == CH_IDX_W'(i))),
         .load_div (wr_div),
         .restart  (sync),
         .div      (div_all[i]),
         .tick     (tick[i]),
         .sq       (sq[i])
      );
   end

   // Readback mux; an index with no channel behind it selects 0.
   always_comb begin
      rd_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_ch == CH_IDX_W'(i)) begin
            rd_sel = div_all[i];
         end else begin
            rd_sel = rd_sel;
         end
      end
   end

   // Registered readback.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_div <= '0;
      end else begin
         rd_div <= rd_sel;
      end
   end

endmodule

// File: tb/tb_tick_gen.sv
module tb_tick_gen;

   localparam int NUM_CH = 8;
   localparam int CNT_W  = 25;
   // ch0=3, ch1=4, ch2=7, ch3=8 ... ch7=12
   localparam logic [NUM_CH*CNT_W-1:0] DIV_INIT =
      {25'd12, 25'd11, 25'd10, 25'd9, 25'd8, 25'd7, 25'd4, 25'd3};

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [3:0]        wr_ch;
   logic [CNT_W-1:0]  wr_div;
   logic [3:0]        rd_ch;
   logic [CNT_W-1:0]  rd_div;
   logic              sync;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] sq;

   int checks = 0;
   int errors = 0;

   tick_gen #(
      .NUM_CH   (NUM_CH),
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_INIT)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_div (wr_div),
      .rd_ch  (rd_ch),
      .rd_div (rd_div),
      .sync   (sync),
      .tick   (tick),
      .sq     (sq)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset(input string tag);
      rst = 1'b1; wr_en = 1'b0; sync = 1'b0;
      wr_ch = 4'd0; wr_div = 25'd0; rd_ch = 4'd0;
      step(); step();
      checks++;
      if (tick !== 8'h00) begin
         errors++; $display("FAIL %s_tick_in_rst got %h exp 00", tag, tick);
      end
      checks++;
      if (rd_div !== 25'd0) begin
         errors++; $display("FAIL %s_rd_in_rst got %0d exp 0", tag, rd_div);
      end
      checks++;
      if (sq !== 8'h00) begin
         errors++; $display("FAIL %s_sq_in_rst got %h exp 00", tag, sq);
      end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         step();
         checks++;
         if (tick[0] !== (k % 3 == 0)) begin
            errors++; $display("FAIL %s_tick0 c%0d got %b exp %b", tag, k, tick[0], (k % 3 == 0));
         end
         checks++;
         if (tick[1] !== (k % 4 == 0)) begin
            errors++; $display("FAIL %s_tick1 c%0d got %b exp %b", tag, k, tick[1], (k % 4 == 0));
         end
         checks++;
         if (tick[2] !== (k % 7 == 0)) begin
            errors++; $display("FAIL %s_tick2 c%0d got %b exp %b", tag, k, tick[2], (k % 7 == 0));
         end
         checks++;
         if (rd_div !== 25'd3) begin
            errors++; $display("FAIL %s_rd0 c%0d got %0d exp 3", tag, k, rd_div);
         end
      end
   endtask

   task automatic test_write();
      step();  // ch0 now mid-period
      wr_en = 1'b1; wr_ch = 4'd0; wr_div = 25'd5;
      step();
      wr_en = 1'b0;
      checks++;
      if (tick[0] !== 1'b0) begin
         errors++; $display("FAIL wr_tick0_at_write got %b exp 0", tick[0]);
      end
      checks++;
      if (rd_div !== 25'd3) begin
         errors++; $display("FAIL wr_rd_at_write got %0d exp 3", rd_div);
      end
      for (int j = 1; j <= 15; j++) begin
         step();
         checks++;
         if (tick[0] !== (j % 5 == 0)) begin
            errors++; $display("FAIL wr_tick0 c%0d got %b exp %b", j, tick[0], (j % 5 == 0));
         end
         checks++;
         if (tick[1] !== ((j + 2) % 4 == 0)) begin
            errors++; $display("FAIL wr_tick1 c%0d got %b exp %b", j, tick[1], ((j + 2) % 4 == 0));
         end
         checks++;
         if (rd_div !== 25'd5) begin
            errors++; $display("FAIL wr_rd0 c%0d got %0d exp 5", j, rd_div);
         end
      end
   endtask

   task automatic test_halt();
      int bad;
      rd_ch = 4'd1;
      wr_en = 1'b1; wr_ch = 4'd1; wr_div = 25'd0;
      step();
      wr_en = 1'b0;
      bad = 0;
      for (int j = 1; j <= 100; j++) begin
         step();
         if (tick[1] !== 1'b0) bad++;
      end
      checks++;
      if (bad !== 0) begin
         errors++; $display("FAIL halt_tick1 got %0d high cycles exp 0", bad);
      end
      checks++;
      if (rd_div !== 25'd0) begin
         errors++; $display("FAIL halt_rd1 got %0d exp 0", rd_div);
      end
      wr_en = 1'b1; wr_ch = 4'd1; wr_div = 25'd1;
      step();
      wr_en = 1'b0;
      checks++;
      if (tick[1] !== 1'b0) begin
         errors++; $display("FAIL div1_tick1_at_write got %b exp 0", tick[1]);
      end
      for (int j = 1; j <= 8; j++) begin
         step();
         checks++;
         if (tick[1] !== 1'b1) begin
            errors++; $display("FAIL div1_tick1 c%0d got %b exp 1", j, tick[1]);
         end
      end
   endtask

   task automatic test_sync();
      wr_en = 1'b1; wr_ch = 4'd0; wr_div = 25'd4;
      step();
      wr_ch = 4'd1; wr_div = 25'd6;
      step();
      wr_en = 1'b0;
      step(); step(); step();
      rd_ch = 4'd9;
      sync = 1'b1;
      step();
      sync = 1'b0;
      checks++;
      if (tick !== 8'h00) begin
         errors++; $display("FAIL sync_tick_at_sync got %h exp 00", tick);
      end
      for (int j = 1; j <= 24; j++) begin
         step();
         checks++;
         if (tick[0] !== (j % 4 == 0)) begin
            errors++; $display("FAIL sync_tick0 c%0d got %b exp %b", j, tick[0], (j % 4 == 0));
         end
         checks++;
         if (tick[1] !== (j % 6 == 0)) begin
            errors++; $display("FAIL sync_tick1 c%0d got %b exp %b", j, tick[1], (j % 6 == 0));
         end
         checks++;
         if (tick[2] !== (j % 7 == 0)) begin
            errors++; $display("FAIL sync_tick2 c%0d got %b exp %b", j, tick[2], (j % 7 == 0));
         end
         checks++;
         if (rd_div !== 25'd0) begin
            errors++; $display("FAIL rd_ch9 c%0d got %0d exp 0", j, rd_div);
         end
         // Out-of-range write lands on the edge ending cycle 6.
         if (j == 5) begin
            wr_en = 1'b1; wr_ch = 4'd9; wr_div = 25'd1;
         end else begin
            wr_en = 1'b0;
         end
      end
   endtask

   task automatic test_back_to_back();
      wr_en = 1'b1; wr_ch = 4'd0; wr_div = 25'd2; sync = 1'b1;
      step();
      wr_en = 1'b0; sync = 1'b0;
      checks++;
      if (tick !== 8'h00) begin
         errors++; $display("FAIL b2b_tick_at_edge got %h exp 00", tick);
      end
      for (int j = 1; j <= 12; j++) begin
         step();
         checks++;
         if (tick[3:0] !== {(j % 8 == 0), (j % 7 == 0), (j % 6 == 0), (j % 2 == 0)}) begin
            errors++; $display("FAIL b2b_tick c%0d got %b exp %b", j, tick[3:0],
                               {(j % 8 == 0), (j % 7 == 0), (j % 6 == 0), (j % 2 == 0)});
         end
      end
   endtask

   task automatic test_readback();
      for (int i = 2; i < NUM_CH; i++) begin
         rd_ch = 4'(i);
         step();
         checks++;
         if (rd_div !== 25'(i + 5)) begin
            errors++; $display("FAIL rd_ch%0d got %0d exp %0d", i, rd_div, i + 5);
         end
      end
      rd_ch = 4'd1;
      step();
      checks++;
      if (rd_div !== 25'd6) begin
         errors++; $display("FAIL rd_ch1 got %0d exp 6", rd_div);
      end
      rd_ch = 4'd15;
      step();
      checks++;
      if (rd_div !== 25'd0) begin
         errors++; $display("FAIL rd_ch15 got %0d exp 0", rd_div);
      end
   endtask

   task automatic test_square();
      logic exp_sq;
      wr_en = 1'b1; wr_ch = 4'd0; wr_div = 25'd2;
      step();
      wr_en = 1'b0;
      for (int j = 0; j <= 12; j++) begin
         if (j > 0) step();
`ifdef TICK_GEN_SQUARE_EN
         exp_sq = (j == 0) ? 1'b0 : (((j - 1) / 2) % 2 == 1);
         checks++;
         if (sq[0] !== exp_sq) begin
            errors++; $display("FAIL sq0 c%0d got %b exp %b", j, sq[0], exp_sq);
         end
`else
         exp_sq = 1'b0;
         checks++;
         if (sq !== {NUM_CH{exp_sq}}) begin
            errors++; $display("FAIL sq_tied c%0d got %h exp 00", j, sq);
         end
`endif
      end
   endtask

   initial begin
      test_reset("rst");
      test_write();
      test_halt();
      test_sync();
      test_back_to_back();
      test_readback();
      test_square();
      step(); step();
      test_reset("midrst");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
